// File: rtl/pipelined_barrel_shifter.sv
// -----------------------------------------------------------------------------
// pipelined_barrel_shifter
//   Parametrised barrel shifter with one register per log2 stage and a
//   valid/ready handshake. Stage k shifts by 2^k when bit k of the amount
//   captured with the operation is set. All stages advance together and all
//   stall together (global stall), so results leave in acceptance order.
//
// Ports
//   clk       rising-edge clock
//   rst       synchronous active-high reset (clears all stage state)
//   in_valid  operand/command valid
//   in_ready  block accepts operands this cycle (= !out_valid | out_ready)
//   a         operand, WIDTH bits
//   b         shift amount, unsigned, SW bits
//   mode      00 LSL, 01 LSR, 10 ASR, 11 ROR
//   out_valid result valid
//   out_ready sink accepts result
//   o         shifted result
//   o_zero    high when o == 0 (only while out_valid)
// -----------------------------------------------------------------------------
module pipelined_barrel_shifter #(
  parameter  int WIDTH = 16,
  localparam int SW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [SW-1:0]    b,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] o,
  output logic             o_zero
);

  localparam logic [1:0] MODE_LSL = 2'b00;
  localparam logic [1:0] MODE_LSR = 2'b01;
  localparam logic [1:0] MODE_ASR = 2'b10;

  // One conditional shift by s positions; ASR takes its fill from the MSB of
  // the data entering this stage, which keeps the sign across all stages.
  function automatic logic [WIDTH-1:0] f_shift_stage(
    input logic [WIDTH-1:0] d,
    input logic             en,
    input logic [1:0]       m,
    input int               s
  );
    logic signed [WIDTH-1:0] sd;
    logic        [WIDTH-1:0] r;
    sd = d;
    r  = d;
    if (en) begin
      case (m)
        MODE_LSL: r = d << s;
        MODE_LSR: r = d >> s;
        MODE_ASR: r = sd >>> s;
        default:  r = (d >> s) | (d << (WIDTH - s));
      endcase
    end
    return r;
  endfunction

  // Stage registers: data and valid for every stage; amount and mode only for
  // stages that still feed a later stage.
  logic [WIDTH-1:0] r_dat  [SW];
  logic [SW-1:0]    r_vld;
  logic [SW-1:0]    r_amt  [SW-1];
  logic [1:0]       r_mode [SW-1];
  logic             r_zero;

  // Combinational inputs/outputs of each stage's shifter.
  logic [WIDTH-1:0] w_din  [SW];
  logic [SW-1:0]    w_ain  [SW];
  logic [1:0]       w_min  [SW];
  logic [WIDTH-1:0] w_dout [SW];
  logic             w_adv;

  assign w_adv = !r_vld[SW-1] || out_ready;

  genvar k;
  generate
    for (k = 0; k < SW; k++) begin : g_stage
      if (k == 0) begin : g_first
        assign w_din[k] = a;
        assign w_ain[k] = b;
        assign w_min[k] = mode;
      end else begin : g_next
        assign w_din[k] = r_dat[k-1];
        assign w_ain[k] = r_amt[k-1];
        assign w_min[k] = r_mode[k-1];
      end
      assign w_dout[k] = f_shift_stage(w_din[k], w_ain[k][k], w_min[k], 1 << k);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld  <= '0;
      r_zero <= 1'b0;
      for (int i = 0; i < SW; i++) r_dat[i] <= '0;
      for (int i = 0; i < SW - 1; i++) begin
        r_amt[i]  <= '0;
        r_mode[i] <= '0;
      end
    end else if (w_adv) begin
      // ---- stage 0: capture (idle cycles load zeros so X never propagates)
      r_vld[0]  <= in_valid;
      r_dat[0]  <= in_valid ? w_dout[0] : '0;
      r_amt[0]  <= in_valid ? b : '0;
      r_mode[0] <= in_valid ? mode : '0;
      // ---- stages 1..SW-1: data and valid move forward together
      for (int i = 1; i < SW; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_dat[i] <= w_dout[i];
      end
      for (int i = 1; i < SW - 1; i++) begin
        r_amt[i]  <= r_amt[i-1];
        r_mode[i] <= r_mode[i-1];
      end
      // ---- final stage flag, qualified by the valid entering it
      r_zero <= r_vld[SW-2] && (w_dout[SW-1] == '0);
    end
  end

  assign in_ready  = w_adv;
  assign out_valid = r_vld[SW-1];
  assign o         = r_dat[SW-1];
  assign o_zero    = r_zero;

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
module tb_pipelined_barrel_shifter;

  logic        clk = 1'b0;
  logic        rst;

  // WIDTH=16 instance
  logic        in_valid, in_ready, out_valid, out_ready, o_zero;
  logic [15:0] a, o;
  logic [3:0]  b;
  logic [1:0]  mode;

  // WIDTH=4 instance
  logic        in_valid4, in_ready4, out_valid4, out_ready4, o_zero4;
  logic [3:0]  a4, o4;
  logic [1:0]  b4;
  logic [1:0]  mode4;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pipelined_barrel_shifter #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
    .o(o), .o_zero(o_zero)
  );

  pipelined_barrel_shifter #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .mode(mode4), .out_valid(out_valid4), .out_ready(out_ready4),
    .o(o4), .o_zero(o_zero4)
  );

  // Reference: whole shift in one step from the mode definitions.
  function automatic logic [31:0] ref_shift(input int w, input logic [31:0] va,
                                            input int sh, input logic [1:0] m);
    logic [31:0] mask, x, r;
    mask = (32'd1 << w) - 32'd1;
    x    = va & mask;
    case (m)
      2'b00:   r = (x << sh) & mask;
      2'b01:   r = x >> sh;
      2'b10: begin
        r = x >> sh;
        if (x[w-1]) r = r | (mask & ~(mask >> sh));
      end
      default: r = ((x >> sh) | (x << (w - sh))) & mask;
    endcase
    return r;
  endfunction

  task automatic do_op16(input logic [15:0] ta, input logic [3:0] tb, input logic [1:0] tm,
                         output int lat, output logic [15:0] res, output logic z);
    @(negedge clk);
    a = ta; b = tb; mode = tm; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    a = 16'($urandom); b = 4'($urandom); mode = 2'($urandom);
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    res = o;
    z   = o_zero;
  endtask

  task automatic do_op4(input logic [3:0] ta, input logic [1:0] tb, input logic [1:0] tm,
                        output int lat, output logic [3:0] res, output logic z);
    @(negedge clk);
    a4 = ta; b4 = tb; mode4 = tm; in_valid4 = 1'b1; out_ready4 = 1'b1;
    @(negedge clk);
    in_valid4 = 1'b0;
    a4 = 4'($urandom); b4 = 2'($urandom); mode4 = 2'($urandom);
    lat = 1;
    while (!out_valid4 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    res = o4;
    z   = o_zero4;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; mode = '0;
    in_valid4 = 1'b0; out_ready4 = 1'b1; a4 = '0; b4 = '0; mode4 = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_tests++; if (o !== 16'h0) begin n_fail++; $display("FAIL reset_o got %h want 0000", o); end
    n_tests++; if (o_zero !== 1'b0) begin n_fail++; $display("FAIL reset_o_zero got %b want 0", o_zero); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_tests++; if (out_valid4 !== 1'b0) begin n_fail++; $display("FAIL reset4_out_valid got %b want 0", out_valid4); end
    n_tests++; if (in_ready4 !== 1'b1) begin n_fail++; $display("FAIL reset4_in_ready got %b want 1", in_ready4); end
  endtask

  task automatic test_legacy();
    logic [15:0] la [6] = '{16'h0100, 16'h0010, 16'h0004, 16'h0002, 16'h0080, 16'h8000};
    logic [3:0]  lb [6] = '{4'd8, 4'd4, 4'd2, 4'd1, 4'd7, 4'd15};
    int lat; logic [15:0] res; logic z;
    for (int i = 0; i < 6; i++) begin
      do_op16(la[i], lb[i], 2'b01, lat, res, z);
      n_tests++; if (lat != 4) begin n_fail++; $display("FAIL legacy_lat[%0d] got %0d want 4", i, lat); end
      n_tests++; if (res !== 16'h0001) begin n_fail++; $display("FAIL legacy_o[%0d] got %h want 0001", i, res); end
      n_tests++; if (z !== 1'b0) begin n_fail++; $display("FAIL legacy_zero[%0d] got %b want 0", i, z); end
    end
  endtask

  task automatic test_modes();
    logic [15:0] ma [8] = '{16'h8000, 16'h0001, 16'h0001, 16'hA5C3, 16'hA5C3, 16'hA5C3, 16'hA5C3, 16'h00FF};
    logic [3:0]  mb [8] = '{4'd15, 4'd15, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd8};
    logic [1:0]  mm [8] = '{2'b10, 2'b00, 2'b11, 2'b00, 2'b01, 2'b10, 2'b11, 2'b01};
    logic [15:0] mo [8] = '{16'hFFFF, 16'h8000, 16'h8000, 16'hA5C3, 16'hA5C3, 16'hA5C3, 16'hA5C3, 16'h0000};
    int lat; logic [15:0] res, ra; logic z; logic [3:0] rb; logic [1:0] rm;
    logic [31:0] e32; logic [15:0] exp16;
    for (int i = 0; i < 8; i++) begin
      do_op16(ma[i], mb[i], mm[i], lat, res, z);
      n_tests++; if (res !== mo[i]) begin n_fail++; $display("FAIL mode_o[%0d] got %h want %h", i, res, mo[i]); end
      n_tests++; if (z !== (mo[i] == 16'h0)) begin n_fail++; $display("FAIL mode_zero[%0d] got %b want %b", i, z, (mo[i] == 16'h0)); end
    end
    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom); rb = 4'($urandom); rm = 2'($urandom);
      if (i % 8 == 0) ra = 16'h0;
      if (i % 8 == 1) rb = 4'd15;
      e32 = ref_shift(16, {16'h0, ra}, int'(rb), rm);
      exp16 = e32[15:0];
      do_op16(ra, rb, rm, lat, res, z);
      n_tests++; if (lat != 4) begin n_fail++; $display("FAIL rand_lat[%0d] got %0d want 4", i, lat); end
      n_tests++; if (res !== exp16) begin n_fail++; $display("FAIL rand_o[%0d] a=%h b=%0d m=%0d got %h want %h", i, ra, rb, rm, res, exp16); end
      n_tests++; if (z !== (exp16 == 16'h0)) begin n_fail++; $display("FAIL rand_zero[%0d] got %b want %b", i, z, (exp16 == 16'h0)); end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] q[$];
    logic [15:0] ca, prev_o, e16; logic [3:0] cb; logic [1:0] cm;
    logic [31:0] e32;
    logic prev_stall;
    int sent, got, cyc;
    sent = 0; got = 0; cyc = 0; prev_stall = 1'b0; prev_o = '0;
    ca = 16'($urandom); cb = 4'($urandom); cm = 2'($urandom);
    while (got < 12 && cyc < 300) begin
      @(negedge clk);
      if (prev_stall) begin
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid cyc %0d got %b want 1", cyc, out_valid); end
        n_tests++; if (o !== prev_o) begin n_fail++; $display("FAIL stall_o cyc %0d got %h want %h", cyc, o, prev_o); end
      end
      out_ready = (cyc % 3 == 0);
      in_valid  = (sent < 12);
      a = ca; b = cb; mode = cm;
      #1;
      n_tests++;
      if (in_ready !== !(out_valid && !out_ready)) begin
        n_fail++; $display("FAIL b2b_in_ready cyc %0d got %b want %b", cyc, in_ready, !(out_valid && !out_ready));
      end
      if (out_valid) begin
        n_tests++;
        if (q.size() == 0) begin
          n_fail++; $display("FAIL b2b_extra cyc %0d got %h want none", cyc, o);
        end else if (o !== q[0]) begin
          n_fail++; $display("FAIL b2b_o cyc %0d got %h want %h", cyc, o, q[0]);
        end
        if (out_ready && q.size() != 0) begin
          void'(q.pop_front());
          got++;
        end
      end
      if (in_valid && in_ready) begin
        e32 = ref_shift(16, {16'h0, ca}, int'(cb), cm);
        e16 = e32[15:0];
        q.push_back(e16);
        sent++;
        ca = 16'($urandom); cb = 4'($urandom); cm = 2'($urandom);
      end
      prev_stall = out_valid && !out_ready;
      prev_o = o;
      cyc++;
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    n_tests++; if (got != 12) begin n_fail++; $display("FAIL b2b_count got %0d want 12", got); end
    n_tests++; if (q.size() != 0) begin n_fail++; $display("FAIL b2b_left got %0d want 0", q.size()); end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_dup cyc %0d got %b want 0", i, out_valid); end
    end
  endtask

  task automatic test_reset_midflight();
    int lat, seen; logic [15:0] res; logic z;
    seen = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; a = 16'h1234 + 16'(i); b = 4'd1; mode = 2'b00;
    end
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) seen++;
      @(negedge clk);
    end
    n_tests++; if (seen != 0) begin n_fail++; $display("FAIL midflight_valid got %0d want 0", seen); end
    do_op16(16'hC001, 4'd3, 2'b10, lat, res, z);
    n_tests++; if (lat != 4) begin n_fail++; $display("FAIL post_reset_lat got %0d want 4", lat); end
    n_tests++; if (res !== 16'hF800) begin n_fail++; $display("FAIL post_reset_o got %h want f800", res); end
  endtask

  task automatic test_width4();
    int lat; logic [3:0] res, ra, e4; logic z; logic [1:0] rb, rm; logic [31:0] e32;
    do_op4(4'b1000, 2'd3, 2'b10, lat, res, z);
    n_tests++; if (lat != 2) begin n_fail++; $display("FAIL w4_asr_lat got %0d want 2", lat); end
    n_tests++; if (res !== 4'b1111) begin n_fail++; $display("FAIL w4_asr got %b want 1111", res); end
    do_op4(4'b0011, 2'd1, 2'b11, lat, res, z);
    n_tests++; if (lat != 2) begin n_fail++; $display("FAIL w4_ror_lat got %0d want 2", lat); end
    n_tests++; if (res !== 4'b1001) begin n_fail++; $display("FAIL w4_ror got %b want 1001", res); end
    for (int i = 0; i < 24; i++) begin
      ra = 4'($urandom); rb = 2'($urandom); rm = 2'($urandom);
      e32 = ref_shift(4, {28'h0, ra}, int'(rb), rm);
      e4 = e32[3:0];
      do_op4(ra, rb, rm, lat, res, z);
      n_tests++; if (res !== e4) begin n_fail++; $display("FAIL w4_rand[%0d] a=%b b=%0d m=%0d got %b want %b", i, ra, rb, rm, res, e4); end
      n_tests++; if (z !== (e4 == 4'h0)) begin n_fail++; $display("FAIL w4_zero[%0d] got %b want %b", i, z, (e4 == 4'h0)); end
    end
  endtask

  initial begin
    test_reset();
    test_legacy();
    test_modes();
    test_back_to_back();
    test_reset_midflight();
    test_width4();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
